sle_bank_ctrl: RTL and testbench

Controller and register bank for a WIDTH-bit row of SLE-style storage cells.
- Sequences the row through three operations: parallel load, serial scan-shift, and synchronous clear-to-constant.
- Exposes the per-cell strobes it drives (enable, select-load) for the cell rows it sequences.
- Gives requesters a request/BUSY/DONE handshake.

---
 rtl/sle_bank_ctrl.sv | 109 ++++++++++
 tb/tb_sle_bank_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sle_bank_ctrl.sv
// Controller and register bank for a row of SLE-style storage cells.
// Sequences parallel load, serial scan-shift and clear-to-constant behind a BUSY/DONE handshake.
module sle_bank_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             START_LOAD,
  input  logic             START_SHIFT,
  input  logic             CLR_REQ,
  input  logic             CLR_VAL,
  input  logic             HOLD,
  input  logic [WIDTH-1:0] PD,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             EN_o,
  output logic             SLn_o,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               done_q, done_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q  <= '0;
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (CLR_REQ) begin
      // Clear wins in every state, aborting any operation and overriding HOLD.
      state_d = StIdle;
      cnt_d   = '0;
      q_d     = {WIDTH{CLR_VAL}};
      done_d  = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (START_LOAD) begin
            state_d = StLoad;
          end else if (START_SHIFT) begin
            state_d = StShift;
            cnt_d   = '0;
          end
        end
        StLoad: begin
          q_d     = PD;
          state_d = StIdle;
          done_d  = 1'b1;
        end
        StShift: begin
          if (!HOLD) begin
            q_d = {q_q[WIDTH-2:0], SI};
            // The WIDTH-th shift exits directly, so the counter wraps instead of holding WIDTH.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_d = StIdle;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    BUSY  = (state_q != StIdle);
    EN_o  = (state_q == StLoad) || ((state_q == StShift) && !HOLD);
    SLn_o = (state_q != StShift);
  end

  assign Q    = q_q;
  assign SO   = q_q[WIDTH-1];
  assign DONE = done_q;

endmodule

// File: tb/tb_sle_bank_ctrl.sv
// Directed self-checking bench for sle_bank_ctrl with hand-computed expectations.
module tb_sle_bank_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RSTn;
  logic             START_LOAD, START_SHIFT, CLR_REQ, CLR_VAL, HOLD, SI;
  logic [WIDTH-1:0] PD;
  logic [WIDTH-1:0] Q;
  logic             SO, EN_o, SLn_o, BUSY, DONE;

  int n_checks = 0;
  int n_pass   = 0;

  sle_bank_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .START_LOAD  (START_LOAD),
    .START_SHIFT (START_SHIFT),
    .CLR_REQ     (CLR_REQ),
    .CLR_VAL     (CLR_VAL),
    .HOLD        (HOLD),
    .PD          (PD),
    .SI          (SI),
    .Q           (Q),
    .SO          (SO),
    .EN_o        (EN_o),
    .SLn_o       (SLn_o),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTn = 1'b0; START_LOAD = 1'b0; START_SHIFT = 1'b0; CLR_REQ = 1'b0;
    CLR_VAL = 1'b0; HOLD = 1'b0; SI = 1'b0; PD = '0;
    #2;
    check("rst_q",    32'(Q),     'h0);
    check("rst_busy", 32'(BUSY),  'h0);
    check("rst_done", 32'(DONE),  'h0);
    check("rst_so",   32'(SO),    'h0);
    check("rst_en",   32'(EN_o),  'h0);
    check("rst_sln",  32'(SLn_o), 'h1);
    #10 RSTn = 1'b1;

    // Parallel load of 0xA5
    PD = 8'hA5; START_LOAD = 1'b1;
    tick();
    START_LOAD = 1'b0;
    #1;
    check("ld_busy",  32'(BUSY),  'h1);
    check("ld_en",    32'(EN_o),  'h1);
    check("ld_sln",   32'(SLn_o), 'h1);
    check("ld_done0", 32'(DONE),  'h0);
    check("ld_q0",    32'(Q),     'h0);
    tick();
    check("ld_q",     32'(Q),     'hA5);
    check("ld_done",  32'(DONE),  'h1);
    check("ld_idle",  32'(BUSY),  'h0);

    // Full scan with SI=1; START_LOAD mid-shift must be ignored
    START_SHIFT = 1'b1; SI = 1'b1; PD = 8'h3C;
    tick();
    START_SHIFT = 1'b0;
    #1;
    check("sh_busy", 32'(BUSY),  'h1);
    check("sh_sln",  32'(SLn_o), 'h0);
    check("sh_en",   32'(EN_o),  'h1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] orig;
      orig = 8'hA5;
      check($sformatf("sh_so%0d", i), 32'(SO), 32'(orig[7-i]));
      check($sformatf("sh_nodone%0d", i), 32'(DONE), 'h0);
      START_LOAD = (i == 2);
      tick();
    end
    START_LOAD = 1'b0;
    check("sh_q",    32'(Q),    'hFF);
    check("sh_done", 32'(DONE), 'h1);
    check("sh_idle", 32'(BUSY), 'h0);
    tick();
    check("sh_done_once", 32'(DONE), 'h0);
    check("sh_noload",    32'(Q),    'hFF);
    check("sh_noload_b",  32'(BUSY), 'h0);

    // Hold: load 0x81, shift twice, hold three cycles, then finish
    PD = 8'h81; START_LOAD = 1'b1;
    tick();
    START_LOAD = 1'b0;
    tick();
    START_SHIFT = 1'b1; SI = 1'b0;
    tick();
    START_SHIFT = 1'b0;
    tick();
    tick();
    check("hd_q2", 32'(Q), 'h04);
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hd_frz%0d", i), 32'(Q),     'h04);
      check($sformatf("hd_en%0d", i),  32'(EN_o),  'h0);
      check($sformatf("hd_sln%0d", i), 32'(SLn_o), 'h0);
      check($sformatf("hd_bsy%0d", i), 32'(BUSY),  'h1);
    end
    HOLD = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("hd_q7",    32'(Q),    'h80);
    check("hd_busy7", 32'(BUSY), 'h1);
    check("hd_nd7",   32'(DONE), 'h0);
    tick();
    check("hd_done",  32'(DONE), 'h1);
    check("hd_idle",  32'(BUSY), 'h0);
    check("hd_q",     32'(Q),    'h00);

    // Clear beats a simultaneous load request
    CLR_REQ = 1'b1; CLR_VAL = 1'b1; START_LOAD = 1'b1; PD = 8'h3C;
    tick();
    CLR_REQ = 1'b0; START_LOAD = 1'b0;
    check("cl_q",    32'(Q),    'hFF);
    check("cl_done", 32'(DONE), 'h1);
    check("cl_busy", 32'(BUSY), 'h0);
    tick();
    check("cl_noload", 32'(Q),    'hFF);
    check("cl_nobusy", 32'(BUSY), 'h0);
    check("cl_done1",  32'(DONE), 'h0);

    // Clear mid-shift after four shifts, with HOLD also asserted
    START_SHIFT = 1'b1; SI = 1'b0;
    tick();
    START_SHIFT = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("cs_q4", 32'(Q), 'hF0);
    CLR_REQ = 1'b1; CLR_VAL = 1'b0; HOLD = 1'b1;
    tick();
    CLR_REQ = 1'b0; HOLD = 1'b0;
    check("cs_q",    32'(Q),    'h00);
    check("cs_busy", 32'(BUSY), 'h0);
    check("cs_done", 32'(DONE), 'h1);

    // Back-to-back: shift requested on the load's DONE cycle
    PD = 8'h5A; START_LOAD = 1'b1;
    tick();
    START_LOAD = 1'b0;
    tick();
    check("bb_ldone", 32'(DONE), 'h1);
    check("bb_lq",    32'(Q),    'h5A);
    START_SHIFT = 1'b1; SI = 1'b1;
    tick();
    START_SHIFT = 1'b0;
    check("bb_busy", 32'(BUSY), 'h1);
    check("bb_nd",   32'(DONE), 'h0);
    check("bb_sln",  32'(SLn_o), 'h0);
    for (int i = 0; i < 7; i++) tick();
    check("bb_nd7",  32'(DONE), 'h0);
    check("bb_b7",   32'(BUSY), 'h1);
    check("bb_q7",   32'(Q),    'h7F);
    tick();
    check("bb_done", 32'(DONE), 'h1);
    check("bb_q",    32'(Q),    'hFF);

    // Asynchronous reset after three shifts
    START_SHIFT = 1'b1; SI = 1'b0;
    tick();
    START_SHIFT = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("ar_q3", 32'(Q), 'hF8);
    #2 RSTn = 1'b0;
    #1;
    check("ar_q",    32'(Q),     'h00);
    check("ar_busy", 32'(BUSY),  'h0);
    check("ar_done", 32'(DONE),  'h0);
    check("ar_sln",  32'(SLn_o), 'h1);
    #2 RSTn = 1'b1;
    tick();
    check("ar_idle", 32'(BUSY), 'h0);
    check("ar_q1",   32'(Q),    'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
